// File: rtl/ex_alu_muldiv_ctrl.sv
// Execute-stage control: ALU opcode decode plus an iterative RV-M multiply/divide unit.
module ex_alu_muldiv_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        fun7,
  input  logic [2:0]        fun3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic              flush,
  output logic [CTRL_W-1:0] control_out,
  output logic              is_md,
  output logic              in_ready,
  output logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   md_result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1001);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        fun3_q, fun3_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   md_result_q, md_result_d;

  logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [PW-1:0]     acc_step, prod_s;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [XLEN-1:0]   quo_step, rem_step, quo_s, rem_s;

  // ALU opcode decode for single-cycle instructions
  always_comb begin
    is_md       = (ALUOp == 2'b10) && (fun7 == 7'b0000001);
    control_out = OP_ADD;
    case (ALUOp)
      2'b00: control_out = OP_ADD;
      2'b01: control_out = OP_SUB;
      2'b10: begin
        if (!is_md) begin
          case ({fun7[5], fun3})
            4'b0000: control_out = OP_ADD;
            4'b1000: control_out = OP_SUB;
            4'b0001: control_out = OP_SLL;
            4'b0010: control_out = OP_SLT;
            4'b0011: control_out = OP_SLTU;
            4'b0100: control_out = OP_XOR;
            4'b0101: control_out = OP_SRL;
            4'b1101: control_out = OP_SRA;
            4'b0110: control_out = OP_OR;
            4'b0111: control_out = OP_AND;
            default: control_out = OP_ADD;
          endcase
        end
      end
      default: begin
        case (fun3)
          3'b000:  control_out = OP_ADD;
          3'b001:  control_out = OP_SLL;
          3'b010:  control_out = OP_SLT;
          3'b011:  control_out = OP_SLTU;
          3'b100:  control_out = OP_XOR;
          3'b101:  control_out = fun7[5] ? OP_SRA : OP_SRL;
          3'b110:  control_out = OP_OR;
          default: control_out = OP_AND;
        endcase
      end
    endcase
  end

  // Operand signedness, magnitudes and division special cases at acceptance
  always_comb begin
    if (fun3[2]) begin
      a_sgn = ~fun3[0];
      b_sgn = ~fun3[0];
    end else begin
      a_sgn = (fun3[1:0] != 2'b11);
      b_sgn = ~fun3[1];
    end
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = a_sgn & (op_a == MIN_NEG) & (op_b == '1);
  end

  // One shift-add / restoring-subtract iteration and sign fix-up of the final step
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_s   = neg_q ? -acc_step : acc_step;
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, divisor_q};
    quo_step = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
    rem_step = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
    quo_s    = neg_q ? -quo_step : quo_step;
    rem_s    = rneg_q ? -rem_step : rem_step;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fun3_d      = fun3_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    md_result_d = md_result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && is_md && !flush) begin
          fun3_d = fun3[1:0];
          cnt_d  = '0;
          if (!fun3[2]) begin
            state_d  = S_MUL;
            neg_d    = a_neg ^ b_neg;
            acc_d    = '0;
            mcand_d  = PW'(a_mag);
            mplier_d = b_mag;
          end else if (div_zero) begin
            state_d     = S_DONE;
            md_result_d = fun3[1] ? op_a : '1;
          end else if (div_ovf) begin
            state_d     = S_DONE;
            md_result_d = fun3[1] ? '0 : op_a;
          end else begin
            state_d   = S_DIV;
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
            rem_d     = '0;
            quo_d     = a_mag;
            divisor_d = b_mag;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          md_result_d = (fun3_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          md_result_d = fun3_q[1] ? rem_s : quo_s;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fun3_q      <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fun3_q      <= fun3_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      md_result_q <= md_result_d;
    end
  end

  // Handshake and pipeline-hold outputs derived from the state register
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign md_result = md_result_q;
  assign stall     = ((state_q == S_IDLE) & in_valid & is_md) |
                     (state_q == S_MUL) | (state_q == S_DIV) |
                     ((state_q == S_DONE) & ~out_ready);

endmodule
